// File: rtl/dmux_pkg.sv
// Shared definitions for the dmux_stream stream demultiplexer.
// Mode encodings; code 3 is reserved and routes like directed.
package dmux_pkg;

  localparam logic [1:0] MODE_DIRECT = 2'd0;
  localparam logic [1:0] MODE_RR     = 2'd1;
  localparam logic [1:0] MODE_BCAST  = 2'd2;

endpackage

// File: rtl/dmux_chan_buf.sv
// One-entry output register slice for a single dmux_stream channel.
// A load wins over a drain, so the slot can refill in the cycle it empties.
module dmux_chan_buf #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             free
);

  assign free = ~valid | ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dmux_stream.sv
// Registered N-way stream demultiplexer: directed, round-robin
// and broadcast routing into per-channel one-entry buffers.
module dmux_stream
  import dmux_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NUM_OUT = 4,
  parameter int SEL_W   = $clog2(NUM_OUT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic [1:0]               mode,
  output logic [NUM_OUT-1:0]       out_valid,
  input  logic [NUM_OUT-1:0]       out_ready,
  output logic [NUM_OUT*WIDTH-1:0] out_data,
  output logic [SEL_W-1:0]         rr_ptr,
  output logic                     sel_err
);

  localparam int NP = 1 << SEL_W;

  logic [NUM_OUT-1:0] free;
  logic [NUM_OUT-1:0] load;
  logic [NP-1:0]      free_pad;
  logic               sel_ok;
  logic               is_rr;
  logic               is_bc;
  logic               is_dir;
  logic               accept;

  assign is_rr  = (mode == MODE_RR);
  assign is_bc  = (mode == MODE_BCAST);
  assign is_dir = ~is_rr & ~is_bc;

  // Pad so out-of-range selects index defined (unused) bits.
  assign free_pad = NP'(free);

  generate
    if (NUM_OUT == NP) begin : g_pow2
      assign sel_ok = 1'b1;
    end else begin : g_npow2
      assign sel_ok = (in_sel < SEL_W'(NUM_OUT));
    end
  endgenerate

  always_comb begin
    in_ready = 1'b0;
    unique case (1'b1)
      is_rr:   in_ready = free_pad[rr_ptr];
      is_bc:   in_ready = &free;
      default: in_ready = sel_ok ? free_pad[in_sel] : 1'b1;
    endcase
  end

  assign accept = in_valid & in_ready;

  generate
    for (genvar i = 0; i < NUM_OUT; i++) begin : g_chan
      assign load[i] = accept & (is_bc
        | (is_rr & (rr_ptr == SEL_W'(i)))
        | (is_dir & sel_ok & (in_sel == SEL_W'(i))));

      dmux_chan_buf #(
        .WIDTH(WIDTH)
      ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load[i]),
        .load_data(in_data),
        .valid    (out_valid[i]),
        .ready    (out_ready[i]),
        .data     (out_data[i*WIDTH +: WIDTH]),
        .free     (free[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      sel_err <= 1'b0;
    end else begin
      sel_err <= accept & is_dir & ~sel_ok;
      if (accept & is_rr) begin
        if (rr_ptr == SEL_W'(NUM_OUT - 1))
          rr_ptr <= '0;
        else
          rr_ptr <= rr_ptr + SEL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dmux_stream.sv
// Directed-vector bench for dmux_stream (4-way) plus a 3-way
// instance for the out-of-range select path.
module tb_dmux_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid, in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_sel, mode;
  logic [3:0]  out_valid, out_ready;
  logic [63:0] out_data;
  logic [1:0]  rr_ptr;
  logic        sel_err;

  logic        c_in_valid, c_in_ready;
  logic [15:0] c_in_data;
  logic [1:0]  c_in_sel, c_mode;
  logic [2:0]  c_out_valid, c_out_ready;
  logic [47:0] c_out_data;
  logic [1:0]  c_rr_ptr;
  logic        c_sel_err;

  always #5 clk = ~clk;

  dmux_stream #(.WIDTH(16), .NUM_OUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .rr_ptr(rr_ptr), .sel_err(sel_err)
  );

  dmux_stream #(.WIDTH(16), .NUM_OUT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_sel(c_in_sel), .mode(c_mode),
    .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .rr_ptr(c_rr_ptr), .sel_err(c_sel_err)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [1:0]  sel;
    logic        vld;
    logic [15:0] d;
    logic [3:0]  ordy;
    logic        erdy;
    logic [3:0]  eov;
    logic [15:0] ed;
    logic [1:0]  err;
  } vec_t;

  vec_t tbl[$];
  int   nv = 0;
  int   nerr = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    nv++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] m, input logic [1:0] s,
                     input logic v, input logic [15:0] d,
                     input logic [3:0] r, input logic er,
                     input logic [3:0] eo, input logic [15:0] ed,
                     input logic [1:0] ep);
    vec_t x;
    x.mode = m; x.sel = s; x.vld = v; x.d = d; x.ordy = r;
    x.erdy = er; x.eov = eo; x.ed = ed; x.err = ep;
    tbl.push_back(x);
  endtask

  initial begin
    // mode sel vld data ordy | rdy ov data rr
    add(0, 0, 1, 16'h000A, 4'hF, 1, 4'b0001, 16'h000A, 0);
    add(0, 1, 1, 16'h000B, 4'hF, 1, 4'b0010, 16'h000B, 0);
    add(0, 2, 1, 16'h000C, 4'hF, 1, 4'b0100, 16'h000C, 0);
    add(0, 3, 1, 16'h000D, 4'hF, 1, 4'b1000, 16'h000D, 0);
    add(0, 3, 0, 16'h0000, 4'hF, 1, 4'b0000, 16'h0000, 0);
    add(0, 2, 1, 16'h1111, 4'b1011, 1, 4'b0100, 16'h1111, 0);
    add(0, 2, 1, 16'h2222, 4'b1011, 0, 4'b0100, 16'h1111, 0);
    add(0, 2, 1, 16'h2222, 4'hF, 1, 4'b0100, 16'h2222, 0);
    add(0, 2, 0, 16'h0000, 4'hF, 1, 4'b0000, 16'h0000, 0);
    add(1, 0, 1, 16'h0001, 4'hF, 1, 4'b0001, 16'h0001, 1);
    add(1, 0, 1, 16'h0002, 4'hF, 1, 4'b0010, 16'h0002, 2);
    add(1, 0, 1, 16'h0003, 4'hF, 1, 4'b0100, 16'h0003, 3);
    add(1, 0, 1, 16'h0004, 4'hF, 1, 4'b1000, 16'h0004, 0);
    add(1, 0, 1, 16'h0005, 4'hF, 1, 4'b0001, 16'h0005, 1);
    add(1, 0, 1, 16'h0006, 4'hF, 1, 4'b0010, 16'h0006, 2);
    add(1, 0, 0, 16'h0000, 4'hF, 1, 4'b0000, 16'h0000, 2);
    add(1, 0, 1, 16'h0007, 4'hF, 1, 4'b0100, 16'h0007, 3);
    add(1, 0, 1, 16'h0008, 4'hF, 1, 4'b1000, 16'h0008, 0);
    add(1, 0, 1, 16'h0009, 4'b1101, 1, 4'b0001, 16'h0009, 1);
    add(0, 1, 1, 16'hAAAA, 4'b1101, 1, 4'b0010, 16'hAAAA, 1);
    add(1, 0, 1, 16'h0010, 4'b1101, 0, 4'b0010, 16'hAAAA, 1);
    add(1, 0, 1, 16'h0010, 4'b1101, 0, 4'b0010, 16'hAAAA, 1);
    add(1, 0, 1, 16'h0010, 4'hF, 1, 4'b0010, 16'h0010, 2);
    add(1, 0, 0, 16'h0000, 4'hF, 1, 4'b0000, 16'h0000, 2);
    add(0, 3, 1, 16'h3333, 4'b0111, 1, 4'b1000, 16'h3333, 2);
    add(2, 0, 1, 16'hBEEF, 4'b0111, 0, 4'b1000, 16'h3333, 2);
    add(2, 0, 1, 16'hBEEF, 4'hF, 1, 4'b1111, 16'hBEEF, 2);
    add(2, 0, 0, 16'h0000, 4'h0, 0, 4'b1111, 16'hBEEF, 2);
    add(0, 0, 0, 16'h0000, 4'hF, 1, 4'b0000, 16'h0000, 2);
    add(3, 2, 1, 16'h5A5A, 4'hF, 1, 4'b0100, 16'h5A5A, 2);
    add(0, 2, 0, 16'h0000, 4'hF, 1, 4'b0000, 16'h0000, 2);

    in_valid = 0; in_data = '0; in_sel = '0; mode = '0; out_ready = '0;
    c_in_valid = 0; c_in_data = '0; c_in_sel = '0; c_mode = '0;
    c_out_ready = 3'b111;

    repeat (2) @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset rr_ptr", rr_ptr, 0);
    chk("reset sel_err", sel_err, 0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      mode = tbl[i].mode; in_sel = tbl[i].sel;
      in_valid = tbl[i].vld; in_data = tbl[i].d;
      out_ready = tbl[i].ordy;
      #1 chk($sformatf("v%0d in_ready", i), in_ready, tbl[i].erdy);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), out_valid, tbl[i].eov);
      chk($sformatf("v%0d rr_ptr", i), rr_ptr, tbl[i].err);
      chk($sformatf("v%0d sel_err", i), sel_err, 0);
      for (int c = 0; c < 4; c++)
        if (tbl[i].eov[c])
          chk($sformatf("v%0d data ch%0d", i, c),
              out_data[c*16 +: 16], tbl[i].ed);
    end

    // Fill every channel, then reset asynchronously between edges.
    @(negedge clk);
    mode = 2; in_valid = 1; in_data = 16'hCAFE; out_ready = 4'h0;
    @(posedge clk);
    #1 chk("fill out_valid", out_valid, 4'hF);
    chk("fill out_data", out_data, {4{16'hCAFE}});
    @(negedge clk);
    in_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("async rst out_valid", out_valid, 0);
    chk("async rst out_data", out_data, 0);
    chk("async rst rr_ptr", rr_ptr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mode = 0;

    // 3-way instance: select 3 is out of range.
    @(negedge clk);
    c_mode = 0; c_in_sel = 2'd3; c_in_valid = 1; c_in_data = 16'h7777;
    #1 chk("n3 in_ready sel3", c_in_ready, 1);
    @(posedge clk);
    #1 chk("n3 sel_err pulse", c_sel_err, 1);
    chk("n3 out_valid drop", c_out_valid, 0);
    @(negedge clk);
    c_in_valid = 0;
    @(posedge clk);
    #1 chk("n3 sel_err clear", c_sel_err, 0);
    chk("n3 out_valid idle", c_out_valid, 0);
    @(negedge clk);
    c_in_sel = 2'd2; c_in_valid = 1; c_in_data = 16'h4242;
    @(posedge clk);
    #1 chk("n3 ch2 valid", c_out_valid, 3'b100);
    chk("n3 ch2 data", c_out_data[32 +: 16], 16'h4242);
    chk("n3 sel_err low", c_sel_err, 0);
    @(negedge clk);
    c_in_valid = 0;

    $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
    $finish;
  end

endmodule

// File: doc/dmux_stream.md
Name: dmux_stream

Overview:
- Registered, parametrised N-way stream demultiplexer; successor of the combinational 4-way DMux.
- Routes one valid/ready input word stream to one of NUM_OUT output channels, each with a one-entry output register.
- Three routing modes: directed (by in_sel), round-robin, broadcast.
- Sits between a single producer (CPU/memory-mapped writer) and multiple consumer ports.

Parameters:
- WIDTH, 16, data word width in bits (Hack word).
- NUM_OUT, 4, number of output channels; must be >= 2.
- SEL_W, $clog2(NUM_OUT), width of in_sel and the round-robin pointer.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the input word this cycle.
- in_data  input  WIDTH  input word.
- in_sel  input  SEL_W  destination channel; used in directed mode only.
- mode  input  2  0=directed, 1=round-robin, 2=broadcast, 3=reserved (treated as directed).
- out_valid  output  NUM_OUT  per-channel output valid.
- out_ready  input  NUM_OUT  per-channel consumer ready.
- out_data  output  NUM_OUT*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- rr_ptr  output  SEL_W  current round-robin target (observability).
- sel_err  output  1  one-cycle pulse: directed word with in_sel >= NUM_OUT was discarded.

Behaviour:
- Reset: asynchronous assert while rst_n=0. out_valid=0, out_data=0, rr_ptr=0, sel_err=0. Reset mid-transfer discards all buffered words.
- free[i] = ~out_valid[i] | out_ready[i], so a buffer draining this cycle may refill in the same cycle.
- in_ready is combinational from state, mode, in_sel and out_ready only, never from in_valid:
  - directed: free[in_sel]; 1 if in_sel >= NUM_OUT.
  - round-robin: free[rr_ptr].
  - broadcast: AND of all free[i].
- Accept = in_valid & in_ready. On accept, target buffer(s) load in_data and set out_valid at the next edge. Latency is 1 cycle. Throughput is 1 word/cycle when the target's out_ready stays high.
- Channel buffer i: clears out_valid on out_ready[i] & out_valid[i] with no simultaneous load. A simultaneous drain and load keeps out_valid=1 with the new data.
- out_data[i] holds its value while out_valid[i]=1 and out_ready[i]=0. It changes only on load.
- Round-robin: rr_ptr advances by 1 on each accept in mode 1 only, wrapping NUM_OUT-1 -> 0. It holds in the other modes and when in_valid=0 or a stall occurs.
- Directed with in_sel >= NUM_OUT (NUM_OUT not a power of two): word is accepted and dropped, and sel_err pulses high for the cycle after the accept. sel_err is registered.
- Mode may change on any cycle. The new mode applies to the next accept. Buffered words are unaffected.
- Broadcast is all-or-nothing: there are no partial loads.

Decomposition:
- Shared package dmux_pkg: mode constants MODE_DIRECT=2'd0, MODE_RR=2'd1, MODE_BCAST=2'd2.
- Sub-module dmux_chan_buf (one-entry register slice: load, data, valid, ready), instantiated NUM_OUT times via generate.
- Top level holds routing decode, the rr_ptr counter and sel_err.

Test Plan:
- Reset: rst_n=0 mid-stream with all channels full -> out_valid=0, rr_ptr=0, out_data=0 immediately, no clock edge required.
- Directed, all out_ready=1, mode=0, in_sel=0,1,2,3 with data 16'h000A..16'h000D on consecutive cycles -> each appears one cycle later on channel 0..3 only.
- Backpressure: mode=0, in_sel=2, out_ready[2]=0, two words 16'h1111 and 16'h2222 -> 16'h1111 held on ch2, in_ready=0 for the second word. Raising out_ready[2] -> 16'h2222 loads the same cycle ch2 drains.
- Round-robin: mode=1, six words 1..6, all ready -> channels 0,1,2,3,0,1 in order, rr_ptr ends at 2. Stall on ch1 -> rr_ptr holds at 1.
- Broadcast: mode=2, 16'hBEEF, out_ready[3]=0 with ch3 full -> in_ready=0 and no channel loads. Once ch3 frees -> all four out_valid=1 with 16'hBEEF.
- NUM_OUT=3: mode=0, in_sel=3 -> in_ready=1, word dropped, sel_err=1 for exactly one cycle, no out_valid change.
